// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI transaction sequencer slice.
//   BYTE_W        - width of the byte engine send/receive handshake
//   DEFAULT_FILL  - byte clocked out while reading
//   TIMER_W       - width of the chip-select spacing timer
//   state_t       - sequencer state encoding
package spi_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEFAULT_FILL = 8'hFF;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;
endpackage

// File: rtl/spi_txn_sequencer_if.sv
// spi_txn_sequencer_if: host-side and byte-engine-side signals of the sequencer.
//   host side  : start, tx_len, rx_len, tx_data/tx_valid/tx_ready,
//                rx_data/rx_valid, busy, done
//   engine side: cs_n, spi_send, spi_tx, spi_busy, spi_new_data, spi_rx
//   slave  modport - the sequencer itself
//   master modport - whoever drives the sequencer (host plus engine)
interface spi_txn_sequencer_if #(
  parameter int LEN_W = 4
);
  import spi_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  tx_len;
  logic [LEN_W-1:0]  rx_len;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              cs_n;
  logic              spi_send;
  logic [BYTE_W-1:0] spi_tx;
  logic              spi_busy;
  logic              spi_new_data;
  logic [BYTE_W-1:0] spi_rx;

  modport slave (
    input  start, tx_len, rx_len, tx_data, tx_valid, spi_busy, spi_new_data, spi_rx,
    output tx_ready, rx_data, rx_valid, busy, done, cs_n, spi_send, spi_tx
  );

  modport master (
    output start, tx_len, rx_len, tx_data, tx_valid, spi_busy, spi_new_data, spi_rx,
    input  tx_ready, rx_data, rx_valid, busy, done, cs_n, spi_send, spi_tx
  );
endinterface

// File: rtl/spi_cs_timer.sv
// spi_cs_timer: loadable down-counter with a zero flag, used to space
// chip-select setup, hold and idle periods.
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_value this cycle
//   load_value  - period minus one
//   zero        - counter has reached zero
module spi_cs_timer
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);
  logic [TIMER_W-1:0] count;

  // Counts down and parks at zero until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: transaction front end for a byte-wide SPI master.
// Sends tx_len host bytes then rx_len fill bytes inside one chip-select
// window, returns the read-phase bytes as an rx_valid pulse stream.
//   clk, rst - clock, synchronous active-high reset
//   bus      - spi_txn_sequencer_if.slave (host and byte-engine handshakes)
module spi_txn_sequencer
  import spi_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD = 4,
  parameter int CS_IDLE = 2,
  parameter logic [BYTE_W-1:0] FILL_BYTE = DEFAULT_FILL
) (
  input  logic clk,
  input  logic rst,
  spi_txn_sequencer_if.slave bus
);
  localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(CS_SETUP - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(CS_HOLD - 1);
  localparam logic [TIMER_W-1:0] IDLE_LOAD  = TIMER_W'(CS_IDLE - 1);
  localparam logic [LEN_W:0]     ONE        = (LEN_W+1)'(1);

  state_t state, state_next;
  logic [LEN_W-1:0]  tx_len_q, tx_len_next, rx_len_q, rx_len_next;
  logic [LEN_W:0]    idx, idx_next;
  logic              cs_n_q, busy_q, done_q, done_next;
  logic              send_q, send_next, rx_valid_q, rx_valid_next;
  logic [BYTE_W-1:0] spi_tx_q, spi_tx_next, rx_data_q, rx_data_next;
  logic              timer_load, timer_zero;
  logic [TIMER_W-1:0] timer_value;

  // Lengths are summed one bit wider so 15+15 cannot wrap.
  logic [LEN_W:0] total, start_total;
  logic           in_write, last_byte, tx_ready_int;
  assign total        = {1'b0, tx_len_q} + {1'b0, rx_len_q};
  assign start_total  = {1'b0, bus.tx_len} + {1'b0, bus.rx_len};
  assign in_write     = idx < {1'b0, tx_len_q};
  assign last_byte    = idx == (total - ONE);
  assign tx_ready_int = (state == ST_LOAD) && in_write && !bus.spi_busy;

  spi_cs_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // State register plus registered outputs; reset doubles as transaction abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      tx_len_q   <= '0;
      rx_len_q   <= '0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      send_q     <= 1'b0;
      spi_tx_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      tx_len_q   <= tx_len_next;
      rx_len_q   <= rx_len_next;
      cs_n_q     <= !(state_next inside {ST_SETUP, ST_LOAD, ST_WAIT, ST_HOLD});
      busy_q     <= state_next != ST_IDLE;
      done_q     <= done_next;
      send_q     <= send_next;
      spi_tx_q   <= spi_tx_next;
      rx_valid_q <= rx_valid_next;
      rx_data_q  <= rx_data_next;
    end
  end

  // Next-state logic; only one engine byte is outstanding because LOAD
  // issues a send and WAIT blocks until its completion pulse.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    tx_len_next   = tx_len_q;
    rx_len_next   = rx_len_q;
    done_next     = 1'b0;
    send_next     = 1'b0;
    spi_tx_next   = spi_tx_q;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data_q;
    timer_load    = 1'b0;
    timer_value   = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (start_total == '0) begin
            done_next = 1'b1;
          end else begin
            tx_len_next = bus.tx_len;
            rx_len_next = bus.rx_len;
            idx_next    = '0;
            timer_load  = 1'b1;
            timer_value = SETUP_LOAD;
            state_next  = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (timer_zero) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_write) begin
          if (bus.tx_valid && tx_ready_int) begin
            send_next   = 1'b1;
            spi_tx_next = bus.tx_data;
            state_next  = ST_WAIT;
          end
        end else if (!bus.spi_busy) begin
          send_next   = 1'b1;
          spi_tx_next = FILL_BYTE;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.spi_new_data) begin
          if (!in_write) begin
            rx_valid_next = 1'b1;
            rx_data_next  = bus.spi_rx;
          end
          idx_next = idx + ONE;
          if (last_byte) begin
            timer_load  = 1'b1;
            timer_value = HOLD_LOAD;
            state_next  = ST_HOLD;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = IDLE_LOAD;
          state_next  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.tx_ready = tx_ready_int;
  assign bus.cs_n     = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.spi_send = send_q;
  assign bus.spi_tx   = spi_tx_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: self-checking bench for spi_txn_sequencer.
// A behavioural byte engine answers each send after a random delay with
// the next byte of a MISO script; expected results come from a
// transaction-level model (bytes out, read bytes back, one done).
module tb_spi_txn_sequencer;
  import spi_pkg::*;

  localparam int LEN_W = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD = 4;
  localparam int CS_IDLE = 2;
  localparam logic [7:0] FILL = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_txn_sequencer_if #(.LEN_W(LEN_W)) bus ();

  spi_txn_sequencer #(
    .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
    .CS_IDLE(CS_IDLE), .FILL_BYTE(FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx_bytes [16];
  logic [7:0] miso_bytes [32];
  logic [7:0] engine_q [$];
  logic [7:0] sent_q [$];
  logic [7:0] rx_q [$];

  int done_cnt, busy_cycles, cs_low_cycles, setup_meas, hold_meas, gap_meas;
  int wide_send = 0, send_cs_high = 0, done_busy = 0, overlap = 0;
  int eng_left = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Byte engine: busy from the cycle after a send, completion pulse later.
  initial begin
    bus.spi_busy = 1'b0;
    bus.spi_new_data = 1'b0;
    bus.spi_rx = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.spi_new_data) begin
        bus.spi_new_data = 1'b0;
        bus.spi_busy = 1'b0;
      end
      if (bus.spi_send) begin
        if (bus.spi_busy) overlap++;
        bus.spi_busy = 1'b1;
        eng_left = $urandom_range(2, 8);
      end else if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) begin
          bus.spi_new_data = 1'b1;
          bus.spi_rx = (engine_q.size() > 0) ? engine_q.pop_front() : 8'($urandom);
        end
      end
    end
  end

  // Monitor on the falling edge: collects bytes and chip-select timing.
  initial begin
    bit prev_cs_n = 1'b1, prev_send = 1'b0, first_pending = 1'b0;
    int low_run = 0, high_run = 0, since_nd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!bus.cs_n) begin
          if (prev_cs_n) begin
            gap_meas = high_run;
            low_run = 0;
            first_pending = 1'b1;
          end
          if (bus.spi_send && first_pending) begin
            setup_meas = low_run;
            first_pending = 1'b0;
          end
          low_run++;
          cs_low_cycles++;
          if (bus.spi_new_data) since_nd = 0;
          else since_nd++;
        end else begin
          if (!prev_cs_n) begin
            hold_meas = since_nd;
            high_run = 0;
          end
          high_run++;
        end
        if (bus.spi_send) begin
          sent_q.push_back(bus.spi_tx);
          if (prev_send) wide_send++;
          if (bus.cs_n) send_cs_high++;
        end
        if (bus.rx_valid) rx_q.push_back(bus.rx_data);
        if (bus.done) begin
          done_cnt++;
          if (bus.busy) done_busy++;
        end
        if (bus.busy) busy_cycles++;
        prev_send = bus.spi_send;
        prev_cs_n = bus.cs_n;
      end
    end
  end

  // Runs one transaction against the model. Drives at negedge+2 so the
  // monitor has already sampled that edge.
  task automatic applyStimulus(input int n_tx, input int n_rx, input int stall_idx, input int stall_len,
                               input bit dup_start, input bit b2b, input bit check_gap, input bit abort);
    int cycles, k, stall_left, sends_at_stall, cs_high_in_stall, total;
    bit pending, timed_out, aborted;
    logic [7:0] exp_byte;
    total = n_tx + n_rx;
    sent_q.delete();
    rx_q.delete();
    done_cnt = 0; busy_cycles = 0; cs_low_cycles = 0;
    setup_meas = -1; hold_meas = -1; gap_meas = -1;
    engine_q.delete();
    for (int i = 0; i < total; i++) engine_q.push_back(miso_bytes[i]);
    bus.start = 1'b1;
    bus.tx_len = LEN_W'(n_tx);
    bus.rx_len = LEN_W'(n_rx);
    bus.tx_valid = (n_tx > 0);
    bus.tx_data = tx_bytes[0];
    k = 0; pending = 0; stall_left = 0; sends_at_stall = 0; cs_high_in_stall = 0;
    cycles = 0; timed_out = 0; aborted = 0;
    while (done_cnt == 0 && !aborted && !timed_out) begin
      @(negedge clk);
      #2;
      cycles++;
      if (cycles > 3000) timed_out = 1'b1;
      bus.start = dup_start && (cycles == 6);
      if (cycles == 1) begin
        bus.tx_len = LEN_W'($urandom);
        bus.rx_len = LEN_W'($urandom);
        if (total > 0) begin
          checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
          checkOutput("cs_low_after_start", 32'(bus.cs_n), 32'd0);
        end
      end
      if (pending) begin
        pending = 1'b0;
        k++;
        if (k < n_tx) begin
          bus.tx_data = tx_bytes[k];
          if (k == stall_idx && stall_len > 0) begin
            bus.tx_valid = 1'b0;
            stall_left = stall_len;
            sends_at_stall = sent_q.size();
          end
        end else begin
          bus.tx_valid = 1'b0;
        end
      end else if (stall_left > 0) begin
        if (bus.cs_n) cs_high_in_stall++;
        stall_left--;
        if (stall_left == 0) begin
          checkOutput("stall_no_send", 32'(sent_q.size()), 32'(sends_at_stall));
          checkOutput("stall_cs_low", 32'(cs_high_in_stall), 32'd0);
          bus.tx_valid = 1'b1;
        end
      end
      if (abort && sent_q.size() == 2) begin
        rst = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("abort_cs_n", 32'(bus.cs_n), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_no_more_sends", 32'(sent_q.size()), 32'd2);
        checkOutput("abort_no_rx", 32'(rx_q.size()), 32'd0);
        aborted = 1'b1;
      end
      pending = bus.tx_valid && bus.tx_ready;
    end
    bus.start = 1'b0;
    bus.tx_valid = 1'b0;
    checkOutput("txn_timeout", 32'(timed_out), 32'd0);
    if (!aborted && !timed_out) begin
      if (!b2b) begin
        repeat (20) @(negedge clk);
        #2;
      end
      checkOutput("done_count", 32'(done_cnt), 32'd1);
      checkOutput("send_count", 32'(sent_q.size()), 32'(total));
      for (int i = 0; i < sent_q.size() && i < total; i++) begin
        exp_byte = (i < n_tx) ? tx_bytes[i] : FILL;
        checkOutput($sformatf("spi_tx[%0d]", i), 32'(sent_q[i]), 32'(exp_byte));
      end
      checkOutput("rx_count", 32'(rx_q.size()), 32'(n_rx));
      for (int i = 0; i < rx_q.size() && i < n_rx; i++)
        checkOutput($sformatf("rx_data[%0d]", i), 32'(rx_q[i]), 32'(miso_bytes[n_tx+i]));
      if (total == 0) begin
        checkOutput("zero_done_latency", 32'(cycles), 32'd1);
        checkOutput("zero_cs_activity", 32'(cs_low_cycles), 32'd0);
        checkOutput("zero_busy", 32'(busy_cycles), 32'd0);
      end else begin
        checkOutput("cs_setup_min", 32'(setup_meas >= CS_SETUP), 32'd1);
        checkOutput("cs_hold_min", 32'(hold_meas >= CS_HOLD), 32'd1);
        if (check_gap) checkOutput("cs_idle_gap", 32'(gap_meas >= CS_IDLE), 32'd1);
      end
    end
  endtask

  initial begin
    int n_tx, n_rx;
    bit b2b, prev_b2b;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.tx_len = '0;
    bus.rx_len = '0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_cs_n", 32'(bus.cs_n), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("reset_spi_send", 32'(bus.spi_send), 32'd0);
    checkOutput("reset_spi_tx", 32'(bus.spi_tx), 32'd0);
    checkOutput("reset_tx_ready", 32'(bus.tx_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;

    $display("[TB] write-only");
    tx_bytes[0] = 8'h06;
    for (int i = 0; i < 32; i++) miso_bytes[i] = 8'($urandom);
    applyStimulus(1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] write-then-read");
    tx_bytes[0] = 8'h9F;
    miso_bytes[0] = 8'h00; miso_bytes[1] = 8'hEF; miso_bytes[2] = 8'h40; miso_bytes[3] = 8'h18;
    applyStimulus(1, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] host stall");
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    applyStimulus(3, 0, 1, 10, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] zero length");
    applyStimulus(0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] start while busy, then back-to-back");
    tx_bytes[0] = 8'h5A; tx_bytes[1] = 8'hC3;
    for (int i = 0; i < 32; i++) miso_bytes[i] = 8'($urandom);
    applyStimulus(2, 2, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-byte");
    tx_bytes[0] = 8'h31; tx_bytes[1] = 8'h32;
    applyStimulus(2, 2, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tx_bytes[0] = 8'hA5;
    applyStimulus(1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] random transactions");
    prev_b2b = 1'b0;
    for (int t = 0; t < 16; t++) begin
      n_tx = $urandom_range(0, 15);
      n_rx = $urandom_range(0, 15);
      b2b = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) miso_bytes[i] = 8'($urandom);
      applyStimulus(n_tx, n_rx, -1, 0, 1'b0, b2b, prev_b2b && (n_tx + n_rx > 0), 1'b0);
      prev_b2b = b2b && (n_tx + n_rx > 0);
    end
    repeat (20) @(negedge clk);
    #2;

    checkOutput("send_pulse_width", 32'(wide_send), 32'd0);
    checkOutput("send_with_cs_high", 32'(send_cs_high), 32'd0);
    checkOutput("done_while_busy", 32'(done_busy), 32'd0);
    checkOutput("engine_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
